firebird7_in_gate1_pwrmgmt_ovrd_sequencer: RTL and testbench
============================================================

// Module: firebird7_in_gate1_pwrmgmt_ovrd_sequencer
// PURPOSE
//  Sequences the hdspsr array power-management overrides requested through the pwrmgmt_ctrl TDR.
//  Sits between the TDR DataOut ports and the array pins.
//  Turns raw override bits into ordered, timed transitions: arm, fast-sleep, deep-sleep, wake, reset pulse.
//  Exposes state and busy status for TDR capture.
// PARAMETERS
//  CNT_W          8   settle-counter width
//  ARM_CYC        2   cycles from ovrd_en assert/deassert until the next action
//  FS_ENTER_CYC   4   fast-sleep entry settle cycles
//  DS_ENTER_CYC   8   deep-sleep entry settle cycles
//  DS_EXIT_CYC   16   deep-sleep wake settle cycles
//  FS_EXIT_CYC    4   fast-sleep wake settle cycles
//  RST_PULSE_CYC  3   async_rst pulse width in cycles
//  Every *_CYC must be >=1 and <2**CNT_W; checked by an elaboration assertion.
// PORTS
//  ijtag_tck        in   1  clock
//  ijtag_reset      in   1  asynchronous, active-low reset
//  req_ovrd_en      in   1  TDR request: take override control
//  req_fastsleep    in   1  TDR request: fast sleep
//  req_deepsleep    in   1  TDR request: deep sleep (implies fast sleep)
//  req_async_rst    in   1  TDR request: rising edge requests one reset pulse
//  hdspsr_pwr_mgmt_ovrd_en  out 1  to array
//  hdspsr_fastsleep_override out 1  to array
//  hdspsr_deepsleep_override out 1  to array
//  hdspsr_async_rst_override out 1  to array
//  seq_busy         out  1  counting state active (ARM, settle, wake, RST, DISARM)
//  seq_state        out  4  current state encoding, from package
// BEHAVIOUR
//  - Requests come from negedge-tck TDR latches in the same domain, so they are used unsynchronised.
//  - Reset: state=S_FUNC, counter=0, rst_pend=0, prev_rst=0, all outputs 0.
//  - All outputs are registered and decoded from the state: no combinational path from the requests.
//  - ovrd_en=1 in every state except S_FUNC.
//  - fastsleep=1 in FS_SETTLE, FAST, DS_SETTLE, DEEP, DS_WAKE.
//  - deepsleep=1 in DS_SETTLE and DEEP only; async_rst=1 in S_RST only.
//  - Entering a counting state loads the counter with X_CYC-1. The state exits the cycle after counter==0.
//  - A counting state therefore lasts exactly X_CYC cycles.
//  - rst_pend is set on a req_async_rst 0->1 edge while ovrd_en is requested.
//  - rst_pend is cleared on entry to S_RST or when req_ovrd_en=0.
//  - Transitions:
//    FUNC:   req_ovrd_en -> ARM
//    ARM:    done -> ACTIVE
//    ACTIVE: priority !req_ovrd_en -> DISARM; rst_pend -> RST; (req_fs|req_ds) -> FS_SETTLE
//    FS_SETTLE: done -> FAST
//    FAST:   !req_ovrd_en|!(fs|ds) -> FS_WAKE; req_ds -> DS_SETTLE
//    DS_SETTLE: done -> DEEP
//    DEEP:   !req_ovrd_en|!req_ds -> DS_WAKE
//    DS_WAKE: done -> FAST
//    FS_WAKE: done -> ACTIVE
//    RST:    done -> ACTIVE
//    DISARM: done -> FUNC
//  - Counting states are not abortable; request changes are evaluated only when done.
//  - Deep sleep is always entered via fast sleep and exited via fast sleep.
//  - A reset request made during sleep stays pending until ACTIVE is reached, after the full wake sequence.
//  - ovrd_en drop while deep: DEEP->DS_WAKE->FAST->FS_WAKE->ACTIVE->DISARM->FUNC.
//  - Reset mid-sequence: all outputs drop to 0 asynchronously, with no wake ordering. This is accepted.
// STRUCTURE
//  - Package firebird7_in_gate1_pwrmgmt_seq_pkg: state enum (4-bit, stable codes for TDR capture).
//    Also holds the default *_CYC constants and the counter-width localparam.
//  - Sub-module firebird7_in_gate1_pwrmgmt_seq_timer: load, decrement, done flag.
//  - The top level holds the FSM, rst_pend edge logic and output decode.
// TESTING
//  1. Hold reset, release, no requests -> state FUNC, all 6 outputs 0 for 20 cycles.
//  2. req_ovrd_en=1 -> ovrd_en=1 on the next edge, busy=1 for 2 cycles, then ACTIVE with busy=0.
//  3. From ACTIVE set req_deepsleep=1 -> fast=1 for 4 cycles, then deep=1 and DEEP.
//     Clear it -> deep=0, fast held 16 cycles, FS_WAKE 4 cycles, fast=0, ACTIVE.
//  4. req_async_rst 0->1 in ACTIVE -> async_rst=1 for exactly 3 cycles, once.
//     Holding req_async_rst high produces no second pulse.
//  5. Pulse req_async_rst while DEEP -> no async_rst until the wake completes.
//     Then a 3-cycle pulse, then ACTIVE.
//  6. Drop req_ovrd_en mid DS_SETTLE -> the settle completes, then the full wake, then DISARM for 2 cycles.
//     Reaches FUNC with ovrd_en=0.
//     Assert ijtag_reset mid-FAST -> all outputs 0 immediately.

Source files
------------

// File: rtl/firebird7_in_gate1_pwrmgmt_seq_pkg.sv
// firebird7_in_gate1_pwrmgmt_seq_pkg: shared state encoding and timing defaults for the
// hdspsr power-management override sequencer.
//   state_e        4-bit state codes, stable because the TDR captures them
//   SEQ_*          default counter width and settle/pulse lengths in tck cycles
//   seq_counting   true for states that run the settle counter (and assert seq_busy)
package firebird7_in_gate1_pwrmgmt_seq_pkg;

  localparam int SEQ_CNT_W         = 8;
  localparam int SEQ_ARM_CYC       = 2;
  localparam int SEQ_FS_ENTER_CYC  = 4;
  localparam int SEQ_DS_ENTER_CYC  = 8;
  localparam int SEQ_DS_EXIT_CYC   = 16;
  localparam int SEQ_FS_EXIT_CYC   = 4;
  localparam int SEQ_RST_PULSE_CYC = 3;

  typedef enum logic [3:0] {
    S_FUNC      = 4'd0,
    S_ARM       = 4'd1,
    S_ACTIVE    = 4'd2,
    S_FS_SETTLE = 4'd3,
    S_FAST      = 4'd4,
    S_DS_SETTLE = 4'd5,
    S_DEEP      = 4'd6,
    S_DS_WAKE   = 4'd7,
    S_FS_WAKE   = 4'd8,
    S_RST       = 4'd9,
    S_DISARM    = 4'd10
  } state_e;

  function automatic logic seq_counting(input state_e s);
    return s inside {S_ARM, S_FS_SETTLE, S_DS_SETTLE, S_DS_WAKE, S_FS_WAKE, S_RST, S_DISARM};
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_pwrmgmt_seq_timer.sv
// firebird7_in_gate1_pwrmgmt_seq_timer: settle down-counter for the override sequencer.
//   ijtag_tck, ijtag_reset  clock, async active-low reset
//   load, load_val          load the counter (takes priority over counting)
//   done                    counter is zero; the counting state exits on the next edge
module firebird7_in_gate1_pwrmgmt_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q);
  always_ff @(posedge ijtag_tck or negedge ijtag_reset)
    if (!ijtag_reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = cnt_q == '0;
endmodule

// File: rtl/firebird7_in_gate1_pwrmgmt_ovrd_sequencer.sv
// firebird7_in_gate1_pwrmgmt_ovrd_sequencer: orders and times hdspsr power-management overrides
// requested through the pwrmgmt_ctrl TDR.
//   ijtag_tck, ijtag_reset        clock, async active-low reset
//   req_ovrd_en/fastsleep/deepsleep/async_rst   TDR request bits (same tck domain)
//   hdspsr_*_override, hdspsr_pwr_mgmt_ovrd_en  registered pins to the array
//   seq_busy, seq_state           status for TDR capture
module firebird7_in_gate1_pwrmgmt_ovrd_sequencer
  import firebird7_in_gate1_pwrmgmt_seq_pkg::*;
#(
  parameter int CNT_W         = SEQ_CNT_W,
  parameter int ARM_CYC       = SEQ_ARM_CYC,
  parameter int FS_ENTER_CYC  = SEQ_FS_ENTER_CYC,
  parameter int DS_ENTER_CYC  = SEQ_DS_ENTER_CYC,
  parameter int DS_EXIT_CYC   = SEQ_DS_EXIT_CYC,
  parameter int FS_EXIT_CYC   = SEQ_FS_EXIT_CYC,
  parameter int RST_PULSE_CYC = SEQ_RST_PULSE_CYC
) (
  input  logic       ijtag_tck,
  input  logic       ijtag_reset,
  input  logic       req_ovrd_en,
  input  logic       req_fastsleep,
  input  logic       req_deepsleep,
  input  logic       req_async_rst,
  output logic       hdspsr_pwr_mgmt_ovrd_en,
  output logic       hdspsr_fastsleep_override,
  output logic       hdspsr_deepsleep_override,
  output logic       hdspsr_async_rst_override,
  output logic       seq_busy,
  output logic [3:0] seq_state
);
  localparam int MAX_CYC = 2 ** CNT_W;
  if (ARM_CYC < 1 || ARM_CYC >= MAX_CYC || FS_ENTER_CYC < 1 || FS_ENTER_CYC >= MAX_CYC ||
      DS_ENTER_CYC < 1 || DS_ENTER_CYC >= MAX_CYC || DS_EXIT_CYC < 1 || DS_EXIT_CYC >= MAX_CYC ||
      FS_EXIT_CYC < 1 || FS_EXIT_CYC >= MAX_CYC || RST_PULSE_CYC < 1 || RST_PULSE_CYC >= MAX_CYC)
  begin : g_bad_cyc
    $error("pwrmgmt sequencer: every *_CYC must be in [1, 2**CNT_W)");
  end

  state_e           state_q, state_d;
  logic             rst_pend_q, rst_pend_d, prev_rst_q, done, load;
  logic [CNT_W-1:0] load_val;
  logic [4:0]       out_q, out_d;

  firebird7_in_gate1_pwrmgmt_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .load       (load),
    .load_val   (load_val),
    .done       (done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FUNC:      if (req_ovrd_en) state_d = S_ARM;
      S_ARM:       if (done) state_d = S_ACTIVE;
      S_ACTIVE:    state_d = !req_ovrd_en ? S_DISARM : rst_pend_q ? S_RST :
                             (req_fastsleep || req_deepsleep) ? S_FS_SETTLE : S_ACTIVE;
      S_FS_SETTLE: if (done) state_d = S_FAST;
      S_FAST:      state_d = (!req_ovrd_en || !(req_fastsleep || req_deepsleep)) ? S_FS_WAKE :
                             req_deepsleep ? S_DS_SETTLE : S_FAST;
      S_DS_SETTLE: if (done) state_d = S_DEEP;
      S_DEEP:      if (!req_ovrd_en || !req_deepsleep) state_d = S_DS_WAKE;
      S_DS_WAKE:   if (done) state_d = S_FAST;
      S_FS_WAKE:   if (done) state_d = S_ACTIVE;
      S_RST:       if (done) state_d = S_ACTIVE;
      S_DISARM:    if (done) state_d = S_FUNC;
      default:     state_d = S_FUNC;
    endcase
  end

  // Counter is loaded with X_CYC-1 on the edge that enters a counting state, so the state
  // holds for exactly X_CYC cycles. No counting state leads directly into another.
  always_comb begin
    load     = state_d != state_q && seq_counting(state_d);
    load_val = state_d == S_ARM       ? CNT_W'(ARM_CYC - 1) :
               state_d == S_FS_SETTLE ? CNT_W'(FS_ENTER_CYC - 1) :
               state_d == S_DS_SETTLE ? CNT_W'(DS_ENTER_CYC - 1) :
               state_d == S_DS_WAKE   ? CNT_W'(DS_EXIT_CYC - 1) :
               state_d == S_FS_WAKE   ? CNT_W'(FS_EXIT_CYC - 1) :
               state_d == S_RST       ? CNT_W'(RST_PULSE_CYC - 1) :
               state_d == S_DISARM    ? CNT_W'(ARM_CYC - 1) : '0;
  end

  // A reset request raised during sleep is held until ACTIVE is reached again.
  always_comb
    rst_pend_d = (!req_ovrd_en || (state_d == S_RST && state_q != S_RST)) ? 1'b0 :
                 (req_async_rst && !prev_rst_q) ? 1'b1 : rst_pend_q;

  // Pins are decoded from the next state so they change on the same edge as seq_state.
  always_comb
    out_d = {seq_counting(state_d),
             state_d == S_RST,
             state_d inside {S_DS_SETTLE, S_DEEP},
             state_d inside {S_FS_SETTLE, S_FAST, S_DS_SETTLE, S_DEEP, S_DS_WAKE},
             state_d != S_FUNC};

  always_ff @(posedge ijtag_tck or negedge ijtag_reset)
    if (!ijtag_reset) begin
      state_q    <= S_FUNC;
      rst_pend_q <= 1'b0;
      prev_rst_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_pend_q <= rst_pend_d;
      prev_rst_q <= req_async_rst;
      out_q      <= out_d;
    end

  assign {seq_busy, hdspsr_async_rst_override, hdspsr_deepsleep_override,
          hdspsr_fastsleep_override, hdspsr_pwr_mgmt_ovrd_en} = out_q;
  assign seq_state = state_q;
endmodule

// File: tb/tb_firebird7_in_gate1_pwrmgmt_ovrd_sequencer.sv
// tb_firebird7_in_gate1_pwrmgmt_ovrd_sequencer: random request stimulus against a cycle-level
// reference model of the override sequencer.
module tb_firebird7_in_gate1_pwrmgmt_ovrd_sequencer;
  import firebird7_in_gate1_pwrmgmt_seq_pkg::*;

  logic clk = 0, rst_n = 0;
  logic r_en = 0, r_fs = 0, r_ds = 0, r_ar = 0;
  logic o_en, o_fs, o_ds, o_ar, busy;
  logic [3:0] st;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  firebird7_in_gate1_pwrmgmt_ovrd_sequencer dut (
    .ijtag_tck                (clk),
    .ijtag_reset              (rst_n),
    .req_ovrd_en              (r_en),
    .req_fastsleep            (r_fs),
    .req_deepsleep            (r_ds),
    .req_async_rst            (r_ar),
    .hdspsr_pwr_mgmt_ovrd_en  (o_en),
    .hdspsr_fastsleep_override(o_fs),
    .hdspsr_deepsleep_override(o_ds),
    .hdspsr_async_rst_override(o_ar),
    .seq_busy                 (busy),
    .seq_state                (st)
  );

  // Reference model: current phase, cycles left in it, and the pending reset request.
  state_e m_st;
  int     m_left;
  bit     m_pend, m_prev;
  int     pulses_seen, pulses_exp;

  function automatic int phase_len(input state_e s);
    case (s)
      S_ARM, S_DISARM: return 2;
      S_FS_SETTLE:     return 4;
      S_DS_SETTLE:     return 8;
      S_DS_WAKE:       return 16;
      S_FS_WAKE:       return 4;
      S_RST:           return 3;
      default:         return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_FUNC; m_left = 0; m_pend = 0; m_prev = 0;
  endtask

  // Advance the model by one tck edge using the requests the DUT will sample on it.
  task automatic model_step();
    state_e n = m_st;
    bit last = m_left == 1;
    bit sleep = r_fs || r_ds;
    case (m_st)
      S_FUNC:   if (r_en) n = S_ARM;
      S_ACTIVE: if (!r_en) n = S_DISARM; else if (m_pend) n = S_RST; else if (sleep) n = S_FS_SETTLE;
      S_FAST:   if (!r_en || !sleep) n = S_FS_WAKE; else if (r_ds) n = S_DS_SETTLE;
      S_DEEP:   if (!r_en || !r_ds) n = S_DS_WAKE;
      default:  if (last) n = (m_st == S_ARM || m_st == S_FS_WAKE || m_st == S_RST) ? S_ACTIVE :
                              (m_st == S_DISARM) ? S_FUNC :
                              (m_st == S_DS_SETTLE) ? S_DEEP : S_FAST;
    endcase
    if (!r_en || (n == S_RST && m_st != S_RST)) m_pend = 0;
    else if (r_ar && !m_prev) m_pend = 1;
    m_prev = r_ar;
    if (n == S_RST && m_st != S_RST) pulses_exp++;
    m_left = (n != m_st) ? phase_len(n) : (m_left > 0 ? m_left - 1 : 0);
    m_st = n;
  endtask

  task automatic compare_all(input string where);
    check({where, ":state"}, 32'(st), 32'(m_st));
    check({where, ":ovrd_en"}, 32'(o_en), 32'(m_st != S_FUNC));
    check({where, ":fast"}, 32'(o_fs), 32'(m_st inside {S_FS_SETTLE, S_FAST, S_DS_SETTLE, S_DEEP, S_DS_WAKE}));
    check({where, ":deep"}, 32'(o_ds), 32'(m_st inside {S_DS_SETTLE, S_DEEP}));
    check({where, ":arst"}, 32'(o_ar), 32'(m_st == S_RST));
    check({where, ":busy"}, 32'(busy), 32'(phase_len(m_st) != 0));
  endtask

  task automatic cycle(input string where);
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (o_ar && m_st == S_RST && m_left == 3) pulses_seen++;
    compare_all(where);
  endtask

  initial begin
    int hold;
    bit found;
    model_reset();
    pulses_seen = 0; pulses_exp = 0;
    #3;
    compare_all("in_reset");
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (20) cycle("idle");

    // Directed: arm, deep sleep round trip, single reset pulse with held request.
    r_en = 1;
    repeat (4) cycle("arm");
    r_ds = 1;
    repeat (14) cycle("ds_enter");
    r_ds = 0;
    repeat (22) cycle("ds_exit");
    r_ar = 1;
    repeat (10) cycle("arst_hold");
    r_ar = 0;
    cycle("arst_low");

    // Random request segments held for a few to tens of cycles.
    repeat (150) begin
      r_en = $urandom_range(0, 99) < 88;
      r_ds = $urandom_range(0, 99) < 40;
      r_fs = $urandom_range(0, 99) < 45;
      r_ar = $urandom_range(0, 1);
      hold = $urandom_range(1, 30);
      for (int i = 0; i < hold; i++) begin
        if ($urandom_range(0, 9) == 0) r_ar = ~r_ar;
        cycle("rand");
      end
    end
    check("pulse_count", 32'(pulses_seen), 32'(pulses_exp));

    // Reach FAST, then assert reset between edges: pins must drop without a clock edge.
    r_en = 1; r_fs = 1; r_ds = 0; r_ar = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle("to_fast");
      found = m_st == S_FAST;
    end
    check("reached_fast", 32'(found), 32'(1));
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1;
    r_en = 0; r_fs = 0;
    repeat (3) cycle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
